// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network readout classifier:
// FSM state encoding, default widths and the saturating increment.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int COUNT_W_DEF  = 8;
    localparam int WINDOW_W_DEF = 16;

    // Holds at max_value instead of wrapping; callers zero-extend to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Per-neuron spike counter: synchronous clear, increment on inc_i,
// saturating at all-ones.
module sat_counter
    import snn_pkg::*;
#(
    parameter int WIDTH = COUNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [WIDTH-1:0] count_next;

    assign count_next = WIDTH'(sat_inc(32'(count_o), 32'(MAX_COUNT)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (inc_i) begin
            count_o <= count_next;
        end
    end

endmodule

// File: rtl/snn_readout_classifier.sv
// Readout stage: counts output-layer spikes over a programmable window,
// then finds the winning neuron with a one-comparator sequential argmax.
module snn_readout_classifier
    import snn_pkg::*;
#(
    parameter  int NUM_NEURONS = 10,
    parameter  int COUNT_W     = COUNT_W_DEF,
    parameter  int WINDOW_W    = WINDOW_W_DEF,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [WINDOW_W-1:0]    window_len_i,
    input  logic [NUM_NEURONS-1:0] spike_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [IDX_W-1:0]       winner_o,
    output logic [COUNT_W-1:0]     winner_count_o,
    output logic                   tie_o,
    output logic                   busy_o,
    input  logic [IDX_W-1:0]       count_sel_i,
    output logic [COUNT_W-1:0]     count_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t              state_reg;
    logic [WINDOW_W-1:0] remaining_reg;
    logic [IDX_W-1:0]    scan_idx_reg;
    logic [COUNT_W-1:0]  max_reg;
    logic [IDX_W-1:0]    winner_reg;
    logic                tie_reg;
    logic                valid_reg;
    logic                busy_reg;

    logic [COUNT_W-1:0]  counts [NUM_NEURONS];
    logic                clr;
    logic [COUNT_W-1:0]  scan_val;
    logic [COUNT_W-1:0]  sel_val;

    assign clr = (state_reg == IDLE) && start_i;

    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_cnt
            sat_counter #(.WIDTH(COUNT_W)) u_cnt (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .clr_i   (clr),
                .inc_i   ((state_reg == COUNT) && spike_i[gi]),
                .count_o (counts[gi])
            );
        end
    endgenerate

    // Explicit muxes keep out-of-range selects (index >= NUM_NEURONS) at zero.
    always_comb begin
        scan_val = '0;
        sel_val  = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (scan_idx_reg == IDX_W'(i)) scan_val = counts[i];
            if (count_sel_i == IDX_W'(i))  sel_val  = counts[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            scan_idx_reg  <= '0;
            max_reg       <= '0;
            winner_reg    <= '0;
            tie_reg       <= 1'b0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_reg     <= COUNT;
                        remaining_reg <= (window_len_i == '0) ? WINDOW_W'(1) : window_len_i;
                        max_reg       <= '0;
                        winner_reg    <= '0;
                        tie_reg       <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                COUNT: begin
                    remaining_reg <= remaining_reg - WINDOW_W'(1);
                    if (remaining_reg <= WINDOW_W'(1)) begin
                        state_reg    <= SCAN;
                        scan_idx_reg <= '0;
                    end
                end
                SCAN: begin
                    if (scan_idx_reg == '0) begin
                        max_reg    <= scan_val;
                        winner_reg <= '0;
                        tie_reg    <= 1'b0;
                    end else if (scan_val > max_reg) begin
                        max_reg    <= scan_val;
                        winner_reg <= scan_idx_reg;
                        tie_reg    <= 1'b0;
                    end else if (scan_val == max_reg) begin
                        tie_reg    <= 1'b1;
                    end
                    if (scan_idx_reg == LAST_IDX) begin
                        state_reg <= DONE;
                        valid_reg <= 1'b1;
                    end else begin
                        scan_idx_reg <= scan_idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (result_ready_i) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign result_valid_o = valid_reg;
    assign winner_o       = winner_reg;
    assign winner_count_o = max_reg;
    assign tie_o          = tie_reg;
    assign busy_o         = busy_reg;
    assign count_o        = sel_val;

endmodule

// File: tb/tb_snn_readout_classifier.sv
// Directed bench for snn_readout_classifier: a default-width instance plus a
// 4-bit-counter instance sharing the same stimulus for the saturation case.
module tb_snn_readout_classifier;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] window_len = '0;
    logic [N-1:0] spike = '0;
    logic        ready = 1'b0;
    logic [3:0]  count_sel = '0;

    logic        valid, tie, busy;
    logic [3:0]  winner;
    logic [7:0]  winner_count, count_rb;
    logic        valid4, tie4, busy4;
    logic [3:0]  winner4;
    logic [3:0]  winner_count4, count_rb4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    snn_readout_classifier dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .window_len_i(window_len),
        .spike_i(spike), .result_valid_o(valid), .result_ready_i(ready),
        .winner_o(winner), .winner_count_o(winner_count), .tie_o(tie),
        .busy_o(busy), .count_sel_i(count_sel), .count_o(count_rb)
    );

    snn_readout_classifier #(.COUNT_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .window_len_i(window_len),
        .spike_i(spike), .result_valid_o(valid4), .result_ready_i(ready),
        .winner_o(winner4), .winner_count_o(winner_count4), .tie_o(tie4),
        .busy_o(busy4), .count_sel_i(count_sel), .count_o(count_rb4)
    );

    typedef struct {
        string       name;
        int          win;
        logic [N-1:0] always_m;
        logic [N-1:0] extra_m;
        int          nextra;
        int          exp_winner;
        int          exp_count;
        int          exp_tie;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start at edge E, drive the window's spikes for edges E+1..E+W, then
    // wait for valid; lat counts edges after E.
    task automatic run_window(input int win, input logic [N-1:0] alw,
                              input logic [N-1:0] extra, input int nextra,
                              output int lat);
        int weff;
        weff = (win == 0) ? 1 : win;
        start = 1'b1;
        window_len = win[15:0];
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 0; k < weff; k++) begin
            spike = alw | ((k < nextra) ? extra : '0);
            @(negedge clk);
            lat++;
        end
        spike = '0;
        while (!valid && lat < 500) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input int ew, input int ec, input int et);
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".valid"}, valid, 1);
        chk({name, ".busy"}, busy, 1);
        chk({name, ".winner"}, winner, ew);
        chk({name, ".count"}, winner_count, ec);
        chk({name, ".tie"}, tie, et);
        $display("[TB] %s: winner=%0d count=%0d tie=%0d latency=%0d", name, winner, winner_count, tie, lat);
    endtask

    task automatic handshake(input string name);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk({name, ".valid_after_ack"}, valid, 0);
        chk({name, ".busy_after_ack"}, busy, 0);
    endtask

    initial begin
        int lat;

        vecs[0] = '{"basic",     4, 10'b00_0000_1000, 10'b00_1000_0000, 2, 3, 4, 0};
        vecs[1] = '{"tie",       3, 10'b00_0010_0100, 10'b0,            0, 2, 3, 1};
        vecs[2] = '{"tie_low",   5, 10'b10_0000_0000, 10'b00_0000_0010, 5, 1, 5, 1};
        vecs[3] = '{"later_win", 6, 10'b01_0000_0000, 10'b00_0001_0000, 3, 8, 6, 0};
        vecs[4] = '{"silent",    2, 10'b0,            10'b0,            0, 0, 0, 1};
        vecs[5] = '{"win0",      0, 10'b00_0100_0000, 10'b0,            0, 6, 1, 0};

        repeat (2) @(negedge clk);
        chk("reset.valid", valid, 0);
        chk("reset.busy", busy, 0);
        chk("reset.winner", winner, 0);
        chk("reset.count", winner_count, 0);
        chk("reset.tie", tie, 0);
        chk("reset.count_o", count_rb, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            int weff;
            weff = (vecs[v].win == 0) ? 1 : vecs[v].win;
            run_window(vecs[v].win, vecs[v].always_m, vecs[v].extra_m, vecs[v].nextra, lat);
            check_result(vecs[v].name, lat, weff + N, vecs[v].exp_winner,
                         vecs[v].exp_count, vecs[v].exp_tie);
            handshake(vecs[v].name);
        end

        // Saturation: 20 spikes into a 4-bit counter pins at 15.
        run_window(20, 10'b1, '0, 0, lat);
        check_result("sat_w8", lat, 30, 0, 20, 0);
        chk("sat4.winner_count", winner_count4, 15);
        chk("sat4.winner", winner4, 0);
        count_sel = 4'd0;
        #1;
        chk("sat4.count_o", count_rb4, 15);
        chk("sat_w8.count_o", count_rb, 20);
        $display("[TB] saturation: count4=%0d count8=%0d", winner_count4, winner_count);
        handshake("sat");

        // Backpressure and ignored starts in COUNT and DONE.
        start = 1'b1; window_len = 16'd3;
        @(negedge clk);
        start = 1'b0; spike = 10'b10;
        @(negedge clk);
        start = 1'b1; window_len = 16'd50;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        spike = '0;
        lat = 3;
        while (!valid && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check_result("bp", lat, 13, 1, 3, 0);
        for (int c = 0; c < 10; c++) begin
            start = (c == 4);
            @(negedge clk);
            chk("bp.hold_valid", valid, 1);
            chk("bp.hold_winner", winner, 1);
            chk("bp.hold_count", winner_count, 3);
            chk("bp.hold_tie", tie, 0);
        end
        start = 1'b0;
        $display("[TB] backpressure: held 10 cycles winner=%0d", winner);
        handshake("bp");
        @(negedge clk);
        chk("bp.idle_stays", busy, 0);
        count_sel = 4'd1;
        #1;
        chk("bp.count_kept", count_rb, 3);

        // Window 0: spikes at E and E+2 must be dropped, only E+1 counts.
        spike = 10'b00_0101_0000;
        start = 1'b1; window_len = 16'd0;
        @(negedge clk);
        start = 1'b0; spike = 10'b00_0001_0000;
        @(negedge clk);
        spike = 10'b00_0101_0000;
        lat = 1;
        while (!valid && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check_result("bound", lat, 11, 4, 1, 0);
        count_sel = 4'd6; #1; chk("bound.n6", count_rb, 0);
        count_sel = 4'd4; #1; chk("bound.n4", count_rb, 1);
        count_sel = 4'd12; #1; chk("bound.sel_oob", count_rb, 0);
        spike = '0;
        handshake("bound");

        // Reset mid-COUNT after three counted spikes.
        start = 1'b1; window_len = 16'd10;
        @(negedge clk);
        start = 1'b0; spike = 10'b100;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        spike = '0;
        #1;
        chk("rst.valid", valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.winner", winner, 0);
        chk("rst.count", winner_count, 0);
        chk("rst.tie", tie, 0);
        for (int i = 0; i < N; i++) begin
            count_sel = i[3:0];
            #1;
            chk("rst.counter", count_rb, 0);
        end
        $display("[TB] reset mid-count: busy=%0d valid=%0d", busy, valid);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_window(2, 10'b10_0000, '0, 0, lat);
        check_result("post_rst", lat, 12, 5, 2, 0);
        count_sel = 4'd2; #1; chk("post_rst.n2", count_rb, 0);
        handshake("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
